// File: rtl/drive_fdm_polar_modulation_unit.sv
// Frequency-multiplexed polar-to-I/Q modulator: per-channel NCO plus envelope phase/amplitude,
// sine-LUT rotation, channel summation and saturation over a 4-stage pipeline.
module drive_fdm_polar_modulation_unit #(
    parameter int NUM_CH             = 4,
    parameter int SIN_LUT_NUM_ENTRY  = 1024,
    parameter int SIN_LUT_ADDR_WIDTH = 10,
    parameter int SIN_LUT_DATA_WIDTH = 8,
    parameter int NCO_WIDTH          = 16,
    parameter int OUTPUT_WIDTH       = 11,
    localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                                               clk,
    input  logic                                               rst,
    input  logic                                               ftw_wr_en,
    input  logic [CHW-1:0]                                     ftw_wr_ch,
    input  logic [NCO_WIDTH-1:0]                               ftw_wr_data,
    input  logic                                               phase_sync,
    input  logic [NUM_CH-1:0]                                  ch_enable,
    input  logic                                               in_valid,
    input  logic [NUM_CH*SIN_LUT_DATA_WIDTH-1:0]               enve_memory_amp,
    input  logic [NUM_CH*SIN_LUT_ADDR_WIDTH-1:0]               enve_memory_phase,
    output logic                                               out_valid,
    output logic signed [OUTPUT_WIDTH-1:0]                     i_out,
    output logic signed [OUTPUT_WIDTH-1:0]                     q_out,
    output logic                                               sat_flag
);

    localparam int unsigned PW    = SIN_LUT_ADDR_WIDTH;
    localparam int unsigned D     = SIN_LUT_DATA_WIDTH;
    localparam int unsigned AW    = SIN_LUT_DATA_WIDTH;
    localparam int unsigned NW    = NCO_WIDTH;
    localparam int unsigned OW    = OUTPUT_WIDTH;
    localparam int unsigned SUMW  = D + $clog2(NUM_CH);
    localparam int unsigned EW    = ((SUMW > OW) ? SUMW : OW) + 1;
    localparam int unsigned PRODW = AW + 1 + D;

    localparam logic [PW-1:0]          QTR  = PW'(SIN_LUT_NUM_ENTRY / 4);
    localparam logic signed [EW-1:0]   OMAX = EW'((longint'(1) <<< (OW - 1)) - 1);
    localparam logic signed [EW-1:0]   OMIN = -OMAX - EW'(1);

    // Elaboration-time sine via range-reduced Taylor series, rounded to nearest
    function automatic int sin_entry(input int k);
        real x;
        real term;
        real sum;
        real scaled;
        int  kk;
        kk   = (k >= SIN_LUT_NUM_ENTRY / 2) ? k - SIN_LUT_NUM_ENTRY : k;
        x    = 6.283185307179586 * $itor(kk) / $itor(SIN_LUT_NUM_ENTRY);
        term = x;
        sum  = x;
        for (int n = 1; n < 24; n++) begin
            term = -term * x * x / $itor((2 * n) * (2 * n + 1));
            sum  = sum + term;
        end
        scaled = $itor((1 << (D - 1)) - 1) * sum;
        return (scaled >= 0.0) ? $rtoi(scaled + 0.5) : -$rtoi(0.5 - scaled);
    endfunction

    logic signed [D-1:0] sin_lut [SIN_LUT_NUM_ENTRY];

    for (genvar k = 0; k < SIN_LUT_NUM_ENTRY; k++) begin : g_lut
        localparam int VAL = sin_entry(k);
        assign sin_lut[k] = D'(VAL);
    end

    logic [NW-1:0]         acc  [NUM_CH];
    logic [NW-1:0]         ftw  [NUM_CH];
    logic [NW-1:0]         acc_cur [NUM_CH];
    logic [PW-1:0]         ph_next [NUM_CH];
    logic                  v1, v2, v3;

    logic [PW-1:0]         ph1  [NUM_CH];
    logic [AW-1:0]         amp1 [NUM_CH];
    logic [AW-1:0]         amp2 [NUM_CH];
    logic [NUM_CH-1:0]     en1, en2;
    logic signed [D-1:0]   sin2 [NUM_CH];
    logic signed [D-1:0]   cos2 [NUM_CH];
    logic signed [D-1:0]   i3   [NUM_CH];
    logic signed [D-1:0]   q3   [NUM_CH];

    logic signed [PRODW-1:0] i_prod [NUM_CH];
    logic signed [PRODW-1:0] q_prod [NUM_CH];
    logic signed [SUMW-1:0]  i_sum, q_sum;
    logic signed [EW-1:0]    i_ext, q_ext;
    logic signed [OW-1:0]    i_sat, q_sat;
    logic                    i_clip, q_clip;

    // Phase sync zeroes the accumulator seen by this cycle's sample
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            acc_cur[c] = phase_sync ? '0 : acc[c];
            ph_next[c] = acc_cur[c][NW-1 -: PW] + enve_memory_phase[c*PW +: PW];
        end
    end

    always_comb begin
        i_sum = '0;
        q_sum = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            i_prod[c] = $signed({1'b0, amp2[c]}) * cos2[c];
            q_prod[c] = $signed({1'b0, amp2[c]}) * sin2[c];
            i_sum     = i_sum + SUMW'(i3[c]);
            q_sum     = q_sum + SUMW'(q3[c]);
        end
        i_ext  = EW'(i_sum);
        q_ext  = EW'(q_sum);
        i_clip = (i_ext > OMAX) || (i_ext < OMIN);
        q_clip = (q_ext > OMAX) || (q_ext < OMIN);
        i_sat  = (i_ext > OMAX) ? OW'(OMAX) : (i_ext < OMIN) ? OW'(OMIN) : OW'(i_ext);
        q_sat  = (q_ext > OMAX) ? OW'(OMAX) : (q_ext < OMIN) ? OW'(OMIN) : OW'(q_ext);
    end

    // NCO state, tuning words, valid chain and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                acc[c] <= '0;
                ftw[c] <= '0;
            end
            v1        <= 1'b0;
            v2        <= 1'b0;
            v3        <= 1'b0;
            out_valid <= 1'b0;
            i_out     <= '0;
            q_out     <= '0;
            sat_flag  <= 1'b0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (in_valid) begin
                    acc[c] <= acc_cur[c] + ftw[c];
                end else if (phase_sync) begin
                    acc[c] <= '0;
                end
                if (ftw_wr_en && (ftw_wr_ch == CHW'(c))) begin
                    ftw[c] <= ftw_wr_data;
                end
            end
            v1        <= in_valid;
            v2        <= v1;
            v3        <= v2;
            out_valid <= v3;
            if (v3) begin
                i_out    <= i_sat;
                q_out    <= q_sat;
                sat_flag <= i_clip || q_clip;
            end else begin
                sat_flag <= 1'b0;
            end
        end
    end

    // Datapath stages: phase add, LUT read, scale; gated by the valid chain
    always_ff @(posedge clk) begin
        en1 <= ch_enable;
        en2 <= en1;
        for (int c = 0; c < NUM_CH; c++) begin
            ph1[c]  <= ph_next[c];
            amp1[c] <= enve_memory_amp[c*AW +: AW];
            amp2[c] <= amp1[c];
            sin2[c] <= sin_lut[ph1[c]];
            cos2[c] <= sin_lut[ph1[c] + QTR];
            i3[c]   <= en2[c] ? D'(i_prod[c] >>> AW) : '0;
            q3[c]   <= en2[c] ? D'(q_prod[c] >>> AW) : '0;
        end
    end

endmodule

// File: tb/tb_drive_fdm_polar_modulation_unit.sv
// Directed bench for the polar modulation unit: default instance plus a 9-bit-output instance for clipping.
module tb_drive_fdm_polar_modulation_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        ftw_wr_en;
    logic [1:0]  ftw_wr_ch;
    logic [15:0] ftw_wr_data;
    logic        phase_sync;
    logic [3:0]  ch_enable;
    logic        in_valid;
    logic [31:0] enve_memory_amp;
    logic [39:0] enve_memory_phase;

    logic               out_valid, sat_flag;
    logic signed [10:0] i_out, q_out;
    logic               ov9, sat9;
    logic signed [8:0]  i9, q9;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    drive_fdm_polar_modulation_unit dut (
        .clk(clk), .rst(rst), .ftw_wr_en(ftw_wr_en), .ftw_wr_ch(ftw_wr_ch),
        .ftw_wr_data(ftw_wr_data), .phase_sync(phase_sync), .ch_enable(ch_enable),
        .in_valid(in_valid), .enve_memory_amp(enve_memory_amp),
        .enve_memory_phase(enve_memory_phase), .out_valid(out_valid),
        .i_out(i_out), .q_out(q_out), .sat_flag(sat_flag)
    );

    drive_fdm_polar_modulation_unit #(.OUTPUT_WIDTH(9)) dut9 (
        .clk(clk), .rst(rst), .ftw_wr_en(ftw_wr_en), .ftw_wr_ch(ftw_wr_ch),
        .ftw_wr_data(ftw_wr_data), .phase_sync(phase_sync), .ch_enable(ch_enable),
        .in_valid(in_valid), .enve_memory_amp(enve_memory_amp),
        .enve_memory_phase(enve_memory_phase), .out_valid(ov9),
        .i_out(i9), .q_out(q9), .sat_flag(sat9)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    int exp_i [5];
    int exp_q [5];

    initial begin
        rst = 1'b1; ftw_wr_en = 1'b0; ftw_wr_ch = 2'd0; ftw_wr_data = 16'h0000;
        phase_sync = 1'b0; ch_enable = 4'b0001; in_valid = 1'b0;
        enve_memory_amp = {4{8'hFF}}; enve_memory_phase = '0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_i_out", 32'($signed(i_out)), 0);
        chk("rst_q_out", 32'($signed(q_out)), 0);
        chk("rst_sat_flag", 32'(sat_flag), 0);

        // Single pulse: latency 4, full-scale cosine
        in_valid = 1'b1; tick(); in_valid = 1'b0;
        for (int n = 1; n < 4; n++) begin
            chk("lat_early_valid", 32'(out_valid), 0);
            tick();
        end
        chk("lat_valid", 32'(out_valid), 1);
        chk("lat_i", 32'($signed(i_out)), 126);
        chk("lat_q", 32'($signed(q_out)), 0);
        chk("lat_sat", 32'(sat_flag), 0);
        chk("lat_i9", 32'($signed(i9)), 126);
        tick();
        chk("lat_late_valid", 32'(out_valid), 0);
        chk("hold_i", 32'($signed(i_out)), 126);

        // Envelope phase of a quarter turn
        enve_memory_phase[9:0] = 10'd256;
        in_valid = 1'b1; tick(); in_valid = 1'b0;
        tick(); tick(); tick();
        chk("ph256_valid", 32'(out_valid), 1);
        chk("ph256_i", 32'($signed(i_out)), 0);
        chk("ph256_q", 32'($signed(q_out)), 126);
        enve_memory_phase = '0;

        // All four channels: 504 fits 11 bits, clips the 9-bit instance
        ch_enable = 4'b1111;
        in_valid = 1'b1; tick(); in_valid = 1'b0;
        tick(); tick(); tick();
        chk("sum_i", 32'($signed(i_out)), 504);
        chk("sum_sat", 32'(sat_flag), 0);
        chk("sat9_i", 32'($signed(i9)), 255);
        chk("sat9_q", 32'($signed(q9)), 0);
        chk("sat9_flag", 32'(sat9), 1);
        tick();
        chk("sat9_flag_idle", 32'(sat9), 0);
        ch_enable = 4'b0001;
        in_valid = 1'b1; tick(); in_valid = 1'b0;
        tick(); tick(); tick();
        chk("one_ch9_i", 32'($signed(i9)), 126);
        chk("one_ch9_sat", 32'(sat9), 0);

        // NCO wrap with FTW 0x4000 over five consecutive samples
        ftw_wr_en = 1'b1; ftw_wr_ch = 2'd0; ftw_wr_data = 16'h4000; tick(); ftw_wr_en = 1'b0;
        exp_i = '{126, 0, -127, 0, 126};
        exp_q = '{0, 126, 0, -127, 0};
        for (int n = 0; n < 8; n++) begin
            in_valid = (n < 5);
            tick();
            if (n >= 3) begin
                chk("wrap_valid", 32'(out_valid), 1);
                chk("wrap_i", 32'($signed(i_out)), exp_i[n-3]);
                chk("wrap_q", 32'($signed(q_out)), exp_q[n-3]);
            end
        end
        in_valid = 1'b0;

        // Accumulator now 0x4000; sync + FTW write collide on the third sample
        exp_i = '{0, -127, 126, 0, 0};
        exp_q = '{126, 0, 0, 126, -127};
        for (int n = 0; n < 8; n++) begin
            in_valid    = (n < 5);
            phase_sync  = (n == 2);
            ftw_wr_en   = (n == 2);
            ftw_wr_data = 16'h8000;
            tick();
            if (n >= 3) begin
                chk("sync_i", 32'($signed(i_out)), exp_i[n-3]);
                chk("sync_q", 32'($signed(q_out)), exp_q[n-3]);
            end
        end
        phase_sync = 1'b0; ftw_wr_en = 1'b0; in_valid = 1'b0;

        // Reset in the middle of a stream drops in-flight samples
        in_valid = 1'b1;
        tick(); tick(); tick();
        rst = 1'b1;
        for (int n = 0; n < 2; n++) begin
            tick();
            chk("mrst_valid", 32'(out_valid), 0);
            chk("mrst_i", 32'($signed(i_out)), 0);
            chk("mrst_q", 32'($signed(q_out)), 0);
            chk("mrst_sat", 32'(sat_flag), 0);
        end
        rst = 1'b0; in_valid = 1'b0;
        for (int n = 0; n < 6; n++) begin
            tick();
            chk("mrst_stale", 32'(out_valid), 0);
        end
        in_valid = 1'b1; tick(); in_valid = 1'b0;
        tick(); tick(); tick();
        chk("post_rst_valid", 32'(out_valid), 1);
        chk("post_rst_i", 32'($signed(i_out)), 126);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
